// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NREQ           = 4;
  localparam int SEL_W          = 2;
  localparam int CNT_W          = 8;
  localparam int MAX_HOLD_LIMIT = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One-hot grant vector for requester k.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] k);
    onehot    = '0;
    onehot[k] = 1'b1;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters and the arbiter.
interface mux4_rr_arbiter_if;
  import mux4_arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  i;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] s;
  logic             valid;
  logic             y;
  logic             timeout;

  // Requester side drives requests and mux data.
  modport master (
    output req, i,
    input  gnt, s, valid, y, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, i,
    output gnt, s, valid, y, timeout
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  // Scan from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path can leave it unassigned and infer a latch.
    any = |req;
    idx = ptr;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[ptr + SEL_W'(off)]) idx = ptr + SEL_W'(off);
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 one-bit mux.
// A grant lasts until its requester drops or MAX_HOLD cycles elapse; an
// IDLE cycle always separates consecutive grants.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4_rr_arbiter_if.slave     bus
);

  // Out-of-range values are pulled into the legal 1..255 window.
  localparam int HOLD_CLAMP = (MAX_HOLD < 1) ? 1 :
                              (MAX_HOLD > MAX_HOLD_LIMIT) ? MAX_HOLD_LIMIT : MAX_HOLD;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CLAMP - 1);

  arb_state_e       state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] s_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [NREQ-1:0]  gnt_q;
  logic             timeout_q;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             valid;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_req = bus.req[s_q];

  // Arbitration FSM with registered grant, select and timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      s_q        <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, regardless of statement order.
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q    <= BUSY;
            gnt_q      <= onehot(pick_idx);
            s_q        <= pick_idx;
            hold_cnt_q <= '0;
          end
        end
        BUSY: begin
          hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          if (!owner_req || hold_cnt_q == HOLD_LAST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= s_q + SEL_W'(1);
            // Still requesting at release means the limit cut it.
            timeout_q <= owner_req;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid       = |gnt_q;
  assign bus.gnt     = gnt_q;
  assign bus.s       = s_q;
  assign bus.valid   = valid;
  assign bus.timeout = timeout_q;
  // Mux output is combinational from i and forced low when no grant is active.
  assign bus.y       = valid ? bus.i[s_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: three arbiters (MAX_HOLD = 1, 2, 8) share one stimulus
// stream; a cycle model fills a scoreboard queue, and each scenario task adds
// its own hand-derived checks.
module tb_mux4_rr_arbiter;
  import mux4_arb_pkg::*;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_v = '0;
  logic [3:0] i_v = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus1 ();
  mux4_rr_arbiter_if bus2 ();
  mux4_rr_arbiter_if bus8 ();

  assign bus1.req = req_v;
  assign bus1.i   = i_v;
  assign bus2.req = req_v;
  assign bus2.i   = i_v;
  assign bus8.req = req_v;
  assign bus8.i   = i_v;

  mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux4_rr_arbiter #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  mux4_rr_arbiter #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  logic [3:0] o_gnt [NDUT];
  logic [1:0] o_s   [NDUT];
  logic       o_valid [NDUT];
  logic       o_y   [NDUT];
  logic       o_to  [NDUT];

  assign o_gnt[0] = bus1.gnt;  assign o_s[0] = bus1.s;  assign o_valid[0] = bus1.valid;
  assign o_y[0]   = bus1.y;    assign o_to[0] = bus1.timeout;
  assign o_gnt[1] = bus2.gnt;  assign o_s[1] = bus2.s;  assign o_valid[1] = bus2.valid;
  assign o_y[1]   = bus2.y;    assign o_to[1] = bus2.timeout;
  assign o_gnt[2] = bus8.gnt;  assign o_s[2] = bus8.s;  assign o_valid[2] = bus8.valid;
  assign o_y[2]   = bus8.y;    assign o_to[2] = bus8.timeout;

  // ---------------------------------------------------------------- model
  typedef struct {
    int         d;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  bit         m_busy [NDUT];
  logic [1:0] m_ptr  [NDUT];
  logic [1:0] m_s    [NDUT];
  int         m_cnt  [NDUT];
  logic [3:0] m_gnt  [NDUT];
  logic       m_to   [NDUT];

  function automatic int hold_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_busy[d] = 1'b0; m_ptr[d] = '0; m_s[d] = '0;
      m_cnt[d] = 0; m_gnt[d] = '0; m_to[d] = 1'b0;
    end
    exp_q.delete();
  endtask

  // Advance every model by one edge using the req value about to be sampled.
  task automatic model_step();
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      m_to[d] = 1'b0;
      if (!m_busy[d]) begin
        bit found = 1'b0;
        for (int o = 0; o < 4; o++) begin
          logic [1:0] k;
          k = m_ptr[d] + 2'(o);
          if (!found && req_v[k]) begin
            found = 1'b1;
            m_s[d] = k;
          end
        end
        if (found) begin
          m_busy[d] = 1'b1;
          m_gnt[d]  = 4'b0001 << m_s[d];
          m_cnt[d]  = 0;
        end
      end else if (!req_v[m_s[d]]) begin
        m_busy[d] = 1'b0; m_gnt[d] = '0; m_ptr[d] = m_s[d] + 2'd1;
      end else if (m_cnt[d] == hold_of(d) - 1) begin
        m_busy[d] = 1'b0; m_gnt[d] = '0; m_ptr[d] = m_s[d] + 2'd1; m_to[d] = 1'b1;
      end else begin
        m_cnt[d]++;
      end
      e.d = d; e.gnt = m_gnt[d]; e.s = m_s[d]; e.to = m_to[d];
      exp_q.push_back(e);
    end
  endtask

  // One clock: push expectations, take the edge, pop and compare all DUTs.
  task automatic cycle();
    exp_t e;
    logic exp_valid, exp_y;
    model_step();
    @(posedge clk);
    #1;
    repeat (NDUT) begin
      e = exp_q.pop_front();
      exp_valid = |e.gnt;
      exp_y = exp_valid ? i_v[e.s] : 1'b0;
      vectors++;
      if ({o_gnt[e.d], o_s[e.d], o_valid[e.d], o_y[e.d], o_to[e.d]} !==
          {e.gnt, e.s, exp_valid, exp_y, e.to}) begin
        miscompares++;
        $display("FAIL sb dut%0d t=%0t: got gnt=%b s=%0d valid=%b y=%b to=%b, want gnt=%b s=%0d valid=%b y=%b to=%b",
                 e.d, $time, o_gnt[e.d], o_s[e.d], o_valid[e.d], o_y[e.d], o_to[e.d],
                 e.gnt, e.s, exp_valid, exp_y, e.to);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_v = '0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if ({o_gnt[d], o_s[d], o_valid[d], o_y[d], o_to[d]} !== 9'b0) begin
        miscompares++;
        $display("FAIL %s dut%0d: got gnt=%b s=%0d valid=%b y=%b to=%b, want all 0",
                 tag, d, o_gnt[d], o_s[d], o_valid[d], o_y[d], o_to[d]);
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; req_v = '0; i_v = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_v = 4'b1111;
    repeat (3) cycle();
    // Mid-grant asynchronous reset: outputs must clear before any edge.
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_v = 4'b1010;
    cycle();
    vectors++;
    if (o_gnt[2] !== 4'b0010 || o_s[2] !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_first_grant: got gnt=%b s=%0d, want gnt=0010 s=1", o_gnt[2], o_s[2]);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want_g;
    logic       want_to;
    apply_reset();
    req_v = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      cycle();
      want_g  = ((c % 3) < 2) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      want_to = ((c % 3) == 2);
      vectors++;
      if (o_gnt[1] !== want_g || o_to[1] !== want_to) begin
        miscompares++;
        $display("FAIL fairness c=%0d: got gnt=%b to=%b, want gnt=%b to=%b",
                 c, o_gnt[1], o_to[1], want_g, want_to);
      end
    end
  endtask

  task automatic test_voluntary();
    apply_reset();
    req_v = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      cycle();
      vectors++;
      if (o_gnt[2] !== 4'b0100 || o_s[2] !== 2'd2) begin
        miscompares++;
        $display("FAIL vol_hold c=%0d: got gnt=%b s=%0d, want gnt=0100 s=2", c, o_gnt[2], o_s[2]);
      end
    end
    // Drop req[2]; the next request pattern is already present for the wrap test.
    req_v = 4'b0011;
    cycle();
    vectors++;
    if (o_gnt[2] !== 4'b0000 || o_to[2] !== 1'b0 || o_s[2] !== 2'd2) begin
      miscompares++;
      $display("FAIL vol_release: got gnt=%b to=%b s=%0d, want gnt=0000 to=0 s=2",
               o_gnt[2], o_to[2], o_s[2]);
    end
  endtask

  // Relies on test_voluntary having left ptr = 3 and req = 0011.
  task automatic test_wrap();
    cycle();
    vectors++;
    if (o_gnt[2] !== 4'b0001 || o_s[2] !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap: got gnt=%b s=%0d, want gnt=0001 s=0", o_gnt[2], o_s[2]);
    end
  endtask

  task automatic test_datapath();
    logic [3:0] pats [5] = '{4'b0100, 4'b0001, 4'b1011, 4'b0101, 4'b0000};
    apply_reset();
    i_v = '0;
    req_v = 4'b0100;
    cycle();
    for (int p = 0; p < 5; p++) begin
      i_v = pats[p];
      #1;
      vectors++;
      if (o_y[2] !== pats[p][2]) begin
        miscompares++;
        $display("FAIL datapath p=%0d: got y=%b, want y=%b (i=%b)", p, o_y[2], pats[p][2], pats[p]);
      end
    end
    req_v = '0;
    cycle();
    i_v = 4'b1111;
    #1;
    vectors++;
    if (o_y[2] !== 1'b0 || o_valid[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL datapath_idle: got y=%b valid=%b, want y=0 valid=0", o_y[2], o_valid[2]);
    end
  endtask

  task automatic test_late_req();
    apply_reset();
    req_v = 4'b1000;
    cycle();
    req_v = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      cycle();
      vectors++;
      if (o_gnt[2] !== 4'b1000) begin
        miscompares++;
        $display("FAIL late_hold c=%0d: got gnt=%b, want gnt=1000", c, o_gnt[2]);
      end
    end
    req_v = 4'b0010;
    cycle();
    vectors++;
    if (o_gnt[2] !== 4'b0000) begin
      miscompares++;
      $display("FAIL late_release: got gnt=%b, want gnt=0000", o_gnt[2]);
    end
    cycle();
    vectors++;
    if (o_gnt[2] !== 4'b0010 || o_s[2] !== 2'd1) begin
      miscompares++;
      $display("FAIL late_grant: got gnt=%b s=%0d, want gnt=0010 s=1", o_gnt[2], o_s[2]);
    end
  endtask

  task automatic test_hold_one();
    apply_reset();
    req_v = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      cycle();
      vectors++;
      if (o_gnt[0] !== ((c % 2 == 0) ? 4'b0001 : 4'b0000) || o_to[0] !== (c % 2 == 1)) begin
        miscompares++;
        $display("FAIL hold_one c=%0d: got gnt=%b to=%b, want gnt=%b to=%b",
                 c, o_gnt[0], o_to[0], (c % 2 == 0) ? 4'b0001 : 4'b0000, (c % 2 == 1));
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      i_v   = 4'($urandom);
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_voluntary();
    test_wrap();
    test_datapath();
    test_late_req();
    test_hold_one();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
